ir_sense_seq: RTL and testbench

- Producer side of the IR sensor bus consumed by the line-error datapath.
- Periodically enables the IR emitters and waits for them to settle.
- Sequences eight A2D conversions through the A2D interface handshake and latches the results into IR_R0..IR_R3 / IR_L0..IR_L3.
- Pulses IR_vld once per complete frame. Runs continuously while en is high.

---
 rtl/ir_pkg.sv | 21 ++
 rtl/ir_sense_sm.sv | 131 +++++++++++++
 rtl/ir_sense_seq.sv | 100 ++++++++++
 tb/tb_ir_sense_seq.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared constants, FSM state encodings and channel map for the IR sensor sequencer.
package ir_pkg;

    localparam int unsigned NUM_IR = 8;
    localparam int unsigned IR_W   = 12;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StSettle = 3'd1;
    localparam logic [2:0] StConv   = 3'd2;
    localparam logic [2:0] StWait   = 3'd3;
    localparam logic [2:0] StDone   = 3'd4;

    // Conversion index -> A2D channel; idx 0..3 = R0..R3, 4..7 = L0..L3.
    localparam logic [NUM_IR*3-1:0] CHNL_MAP =
        {3'd6, 3'd5, 3'd7, 3'd3, 3'd2, 3'd4, 3'd0, 3'd1};

    function automatic logic [2:0] chnl_map(input logic [2:0] idx);
        return CHNL_MAP[int'(idx)*3 +: 3];
    endfunction

endpackage

// File: rtl/ir_sense_sm.sv
// Frame sequencer: frame timer, emitter settle, eight A2D handshakes with timeout.
module ir_sense_sm
    import ir_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES   = 1000000,
    parameter int unsigned SETTLE_CYCLES  = 4096,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       cnv_cmplt,
    output logic       strt_cnv,
    output logic [2:0] chnnl,
    output logic       ir_en,
    output logic       ir_vld,
    output logic       capture,
    output logic [2:0] idx,
    output logic       last,
    output logic       abort
);

    localparam int unsigned FW = $clog2(FRAME_CYCLES + 1);
    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [FW-1:0] FrameMax   = FW'(FRAME_CYCLES);
    localparam logic [SW-1:0] SettleLast = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TmoLast    = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          first_q, first_d;
    logic          start;

    // The first frame after reset does not wait for the frame timer.
    assign start = (state_q == StIdle) && en && (first_q || (frame_q == FrameMax));

    always_comb begin
        frame_d = frame_q;
        if (start) begin
            frame_d = FW'(1);
        end else if (en && (frame_q != FrameMax)) begin
            frame_d = frame_q + 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        tmo_d    = tmo_q;
        first_d  = first_q;
        capture  = 1'b0;
        last     = 1'b0;
        abort    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StSettle;
                    settle_d = '0;
                    first_d  = 1'b0;
                end
            end
            StSettle: begin
                if (settle_q == SettleLast) begin
                    state_d = StConv;
                    idx_d   = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            StConv: begin
                tmo_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                // A completion in the timeout's final cycle still wins.
                if (cnv_cmplt) begin
                    capture = 1'b1;
                    if (idx_q == 3'd7) begin
                        last    = 1'b1;
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StConv;
                    end
                end else if (tmo_q == TmoLast) begin
                    abort   = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            settle_q <= '0;
            tmo_q    <= '0;
            frame_q  <= '0;
            first_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            tmo_q    <= tmo_d;
            frame_q  <= frame_d;
            first_q  <= first_d;
        end
    end

    assign strt_cnv = (state_q == StConv);
    assign ir_en    = (state_q == StSettle) || (state_q == StConv) || (state_q == StWait);
    assign ir_vld   = (state_q == StDone);
    assign chnnl    = ((state_q == StConv) || (state_q == StWait)) ? chnl_map(idx_q) : 3'd0;
    assign idx      = idx_q;

endmodule

// File: rtl/ir_sense_seq.sv
// IR sensor bus producer: staging and frame-atomic output registers around the sequencer.
module ir_sense_seq
    import ir_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES   = 1000000,
    parameter int unsigned SETTLE_CYCLES  = 4096,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    output logic            strt_cnv,
    output logic [2:0]      chnnl,
    input  logic            cnv_cmplt,
    input  logic [IR_W-1:0] res,
    output logic            IR_en,
    output logic [IR_W-1:0] IR_R0,
    output logic [IR_W-1:0] IR_R1,
    output logic [IR_W-1:0] IR_R2,
    output logic [IR_W-1:0] IR_R3,
    output logic [IR_W-1:0] IR_L0,
    output logic [IR_W-1:0] IR_L1,
    output logic [IR_W-1:0] IR_L2,
    output logic [IR_W-1:0] IR_L3,
    output logic            IR_vld,
    output logic            a2d_err
);

    logic            capture;
    logic            last;
    logic            abort;
    logic [2:0]      idx;
    logic [IR_W-1:0] staging_q [NUM_IR];
    logic [IR_W-1:0] ir_q      [NUM_IR];
    logic            err_q;

    ir_sense_sm #(
        .FRAME_CYCLES  (FRAME_CYCLES),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_sm (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .cnv_cmplt(cnv_cmplt),
        .strt_cnv (strt_cnv),
        .chnnl    (chnnl),
        .ir_en    (IR_en),
        .ir_vld   (IR_vld),
        .capture  (capture),
        .idx      (idx),
        .last     (last),
        .abort    (abort)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_IR; i++) begin
                staging_q[i] <= '0;
            end
        end else if (capture) begin
            staging_q[idx] <= res;
        end
    end

    // L3 bypasses staging so the whole frame lands on the IR_vld cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_IR; i++) begin
                ir_q[i] <= '0;
            end
        end else if (last) begin
            for (int i = 0; i < NUM_IR - 1; i++) begin
                ir_q[i] <= staging_q[i];
            end
            ir_q[NUM_IR-1] <= res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (abort) begin
            err_q <= 1'b1;
        end else if (last) begin
            err_q <= 1'b0;
        end
    end

    assign IR_R0   = ir_q[0];
    assign IR_R1   = ir_q[1];
    assign IR_R2   = ir_q[2];
    assign IR_R3   = ir_q[3];
    assign IR_L0   = ir_q[4];
    assign IR_L1   = ir_q[5];
    assign IR_L2   = ir_q[6];
    assign IR_L3   = ir_q[7];
    assign a2d_err = err_q;

endmodule

// File: tb/tb_ir_sense_seq.sv
// Self-checking bench for ir_sense_seq: A2D responder plus transaction-level frame model.
module tb_ir_sense_seq;

    localparam int unsigned FRAME  = 300;
    localparam int unsigned SETTLE = 8;
    localparam int unsigned TMO    = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        cnv_cmplt = 1'b0;
    logic [11:0] res = '0;
    logic        strt_cnv, IR_en, IR_vld, a2d_err;
    logic [2:0]  chnnl;
    logic [11:0] IR_R0, IR_R1, IR_R2, IR_R3, IR_L0, IR_L1, IR_L2, IR_L3;

    ir_sense_seq #(
        .FRAME_CYCLES  (FRAME),
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .strt_cnv (strt_cnv),
        .chnnl    (chnnl),
        .cnv_cmplt(cnv_cmplt),
        .res      (res),
        .IR_en    (IR_en),
        .IR_R0    (IR_R0),
        .IR_R1    (IR_R1),
        .IR_R2    (IR_R2),
        .IR_R3    (IR_R3),
        .IR_L0    (IR_L0),
        .IR_L1    (IR_L1),
        .IR_L2    (IR_L2),
        .IR_L3    (IR_L3),
        .IR_vld   (IR_vld),
        .a2d_err  (a2d_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected conversion order, as channel numbers.
    int ref_map [8] = '{1, 0, 4, 2, 3, 7, 5, 6};

    // Responder knobs (written by the main sequence only).
    int lat_min = 5;
    int lat_max = 5;
    bit rand_res = 1'b0;
    bit spur = 1'b0;
    int drop_ch = -1;

    // Model state (written by the monitor only).
    int          cyc = 0;
    int          pend = 0;
    logic [11:0] pend_val = '0;
    int          pend_pos = 0;
    logic [11:0] frame_res [8];
    int          frame_ch [8];
    logic [11:0] exp_out [8];
    int          nstrt = 0;
    int          strt_total = 0;
    int          rise_cyc = 0;
    int          rise_cnt = 0;
    int          rise_gap = 0;
    int          settle_delay = 0;
    int          last_ans_cyc = 0;
    int          vld_cnt = 0;
    int          vld_cyc = 0;
    int          vld_gap = 0;
    int          err_rise_cyc = 0;
    logic        err_ir_en = 1'b0;
    logic        err_at_rise = 1'b0;
    int          drop_strt_cyc = 0;
    int          unstable = 0;
    logic        prev_ir_en = 1'b0;
    logic        prev_err = 1'b0;
    logic        prev_rst = 1'b1;

    // Monitor and A2D responder share one process so sampling precedes driving.
    initial begin
        logic [11:0] o [8];
        for (int i = 0; i < 8; i++) begin
            frame_res[i] = '0;
            frame_ch[i]  = 0;
            exp_out[i]   = '0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            o = '{IR_R0, IR_R1, IR_R2, IR_R3, IR_L0, IR_L1, IR_L2, IR_L3};
            if (prev_rst) begin
                for (int i = 0; i < 8; i++) exp_out[i] = '0;
                nstrt = 0;
            end
            if (IR_en === 1'b1 && prev_ir_en !== 1'b1) begin
                if (rise_cnt > 0) rise_gap = cyc - rise_cyc;
                rise_cnt++;
                rise_cyc    = cyc;
                nstrt       = 0;
                err_at_rise = a2d_err;
            end
            if (a2d_err === 1'b1 && prev_err !== 1'b1) begin
                err_rise_cyc = cyc;
                err_ir_en    = IR_en;
            end
            if (IR_vld === 1'b1) begin
                vld_cnt++;
                if (vld_cnt > 1) vld_gap = cyc - vld_cyc;
                vld_cyc = cyc;
                check("vld_nstrt", nstrt, 8);
                check("vld_latency", cyc - last_ans_cyc, 1);
                check("vld_err_clr", a2d_err, 0);
                check("vld_ir_en_low", IR_en, 0);
                for (int i = 0; i < 8; i++) begin
                    check($sformatf("order%0d", i), frame_ch[i], ref_map[i]);
                    check($sformatf("out%0d", i), o[i], frame_res[i]);
                    exp_out[i] = frame_res[i];
                end
            end else begin
                for (int i = 0; i < 8; i++) if (o[i] !== exp_out[i]) unstable++;
            end

            cnv_cmplt = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    cnv_cmplt = 1'b1;
                    res = pend_val;
                    frame_res[pend_pos] = pend_val;
                    last_ans_cyc = cyc;
                end
            end
            if (strt_cnv === 1'b1) begin
                strt_total++;
                if (nstrt == 0) settle_delay = cyc - rise_cyc;
                if (nstrt < 8) frame_ch[nstrt] = int'(chnnl);
                if (int'(chnnl) == drop_ch) begin
                    drop_strt_cyc = cyc;
                end else begin
                    pend     = int'($urandom_range(lat_max, lat_min));
                    pend_val = rand_res ? 12'($urandom) : 12'h100 + 12'(chnnl);
                    pend_pos = nstrt;
                end
                // Completion on the strt_cnv cycle must be ignored.
                if (spur && !cnv_cmplt && $urandom_range(1, 0) == 1) begin
                    cnv_cmplt = 1'b1;
                    res = 12'($urandom);
                end
                nstrt++;
            end else if (spur && IR_en === 1'b1 && pend == 0 && !cnv_cmplt
                         && $urandom_range(3, 0) == 0) begin
                cnv_cmplt = 1'b1;
                res = 12'($urandom);
            end
            prev_ir_en = IR_en;
            prev_err   = a2d_err;
            prev_rst   = rst;
        end
    end

    task automatic wait_vld(input int max_cyc, input string tag);
        int s;
        int k;
        s = vld_cnt;
        k = 0;
        while (vld_cnt == s && k < max_cyc) begin
            @(posedge clk);
            k++;
        end
        #1;
        check(tag, vld_cnt > s, 1);
    endtask

    task automatic wait_rise(input int max_cyc, input string tag);
        int s;
        int k;
        s = rise_cnt;
        k = 0;
        while (rise_cnt == s && k < max_cyc) begin
            @(posedge clk);
            k++;
        end
        #1;
        check(tag, rise_cnt > s, 1);
    endtask

    initial begin
        int k;
        int s;
        int d;
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ir_en", IR_en, 0);
        check("rst_strt", strt_cnv, 0);
        check("rst_vld", IR_vld, 0);
        check("rst_err", a2d_err, 0);
        check("rst_chnnl", chnnl, 0);
        check("rst_r0", IR_R0, 0);
        check("rst_l3", IR_L3, 0);
        rst = 1'b0;

        // First frame right after reset, fixed A2D latency of 5.
        wait_vld(400, "frame1_vld");
        check("settle_delay", settle_delay, SETTLE);
        check("f1_r0", IR_R0, 12'h101);
        check("f1_r1", IR_R1, 12'h100);
        check("f1_r2", IR_R2, 12'h104);
        check("f1_r3", IR_R3, 12'h102);
        check("f1_l0", IR_L0, 12'h103);
        check("f1_l1", IR_L1, 12'h107);
        check("f1_l2", IR_L2, 12'h105);
        check("f1_l3", IR_L3, 12'h106);

        repeat (100) @(posedge clk);
        #1;
        check("idle_ir_en", IR_en, 0);
        wait_vld(400, "frame2_vld");
        check("vld_spacing", vld_gap, FRAME);

        // Random results, random latency, spurious completions.
        rand_res = 1'b1;
        spur     = 1'b1;
        lat_min  = 1;
        lat_max  = 8;
        for (int f = 0; f < 4; f++) begin
            wait_vld(400, "rand_vld");
            check("start_spacing", rise_gap, FRAME);
        end

        // Withhold channel 4: frame aborts on timeout.
        spur    = 1'b0;
        drop_ch = 4;
        s = vld_cnt;
        k = 0;
        while (a2d_err !== 1'b1 && k < 500) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("tmo_err_set", a2d_err, 1);
        d = err_rise_cyc - drop_strt_cyc;
        if (d < 50 || d > 51) check("tmo_delay", d, 51);
        else check("tmo_delay", 1, 1);
        check("tmo_ir_en", err_ir_en, 0);
        check("tmo_no_vld", vld_cnt, s);
        check("tmo_outs_kept", IR_L3, exp_out[7]);
        drop_ch = -1;
        wait_rise(400, "after_tmo_rise");
        check("err_sticky", err_at_rise, 1);
        wait_vld(200, "after_tmo_vld");
        check("err_cleared", a2d_err, 0);

        // Drop en during SETTLE: frame still completes, then nothing.
        wait_rise(400, "en_drop_rise");
        @(posedge clk);
        #1;
        en = 1'b0;
        wait_vld(200, "en_drop_vld");
        s = strt_total;
        d = vld_cnt;
        repeat (1000) @(posedge clk);
        #1;
        check("no_strt_after_en_drop", strt_total - s, 0);
        check("no_vld_after_en_drop", vld_cnt - d, 0);

        // Reset during WAIT for idx 5.
        rand_res = 1'b0;
        lat_min  = 5;
        lat_max  = 5;
        en = 1'b1;
        k = 0;
        while (nstrt != 6 && k < 600) begin
            @(posedge clk);
            k++;
        end
        check("reach_idx5", nstrt, 6);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_ir_en", IR_en, 0);
        check("mid_rst_strt", strt_cnv, 0);
        check("mid_rst_vld", IR_vld, 0);
        check("mid_rst_chnnl", chnnl, 0);
        check("mid_rst_r1", IR_R1, 0);
        check("mid_rst_l2", IR_L2, 0);
        rst = 1'b0;
        s = vld_cnt;
        wait_vld(200, "post_rst_vld");
        check("post_rst_vld_once", vld_cnt - s, 1);
        check("post_rst_settle", settle_delay, SETTLE);
        check("post_rst_l1", IR_L1, 12'h107);

        check("outputs_stable", unstable, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
